// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues imem reads,
// tracks in-flight requests and buffers returned instructions for decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_PC,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_PC,
   input  logic        inst_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int UW = CW + 2;

   logic [31:0]   fetch_pc;

   logic [31:0]   ifq [DEPTH];
   logic [PW-1:0] ifq_wr;
   logic [PW-1:0] ifq_rd;
   logic [CW-1:0] ifq_cnt;

   logic [31:0]   buf_pc   [DEPTH];
   logic [31:0]   buf_inst [DEPTH];
   logic [PW-1:0] buf_wr;
   logic [PW-1:0] buf_rd;
   logic [CW-1:0] buf_cnt;

   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] drop_sum;
   logic [CW-1:0] drop_next;

   logic [UW-1:0] used;
   logic          pop;
   logic          accept;
   logic          resp_take;
   logic          resp_drop;
   logic [1:0]    unused_pc_lo;

   assign unused_pc_lo = redirect_PC[1:0];

   assign inst_valid = buf_cnt != '0;
   assign inst       = buf_inst[buf_rd];
   assign inst_PC    = buf_pc[buf_rd];
   assign pop        = inst_valid && inst_ready;

   // A slot freed by this cycle's pop is reusable, which sustains
   // one instruction per cycle with a single-cycle memory.
   always_comb begin
      used = UW'(ifq_cnt) + UW'(drop_cnt) + UW'(buf_cnt)
           - UW'(pop);
   end

   assign imem_req_valid = !rst && !redirect_valid
                        && (used < UW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign resp_drop = imem_resp_valid && drop_cnt != '0;
   assign resp_take = imem_resp_valid && drop_cnt == '0
                   && ifq_cnt != '0;

   // Everything still in flight at a redirect becomes stale.
   assign drop_sum  = drop_cnt + ifq_cnt;
   assign drop_next = drop_sum
                    - CW'(imem_resp_valid && drop_sum != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         ifq_wr   <= '0;
         ifq_rd   <= '0;
         ifq_cnt  <= '0;
         buf_wr   <= '0;
         buf_rd   <= '0;
         buf_cnt  <= '0;
         drop_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ifq[i]      <= '0;
            buf_pc[i]   <= '0;
            buf_inst[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_PC[31:2], 2'b00};
         ifq_wr   <= '0;
         ifq_rd   <= '0;
         ifq_cnt  <= '0;
         buf_wr   <= '0;
         buf_rd   <= '0;
         buf_cnt  <= '0;
         drop_cnt <= drop_next;
      end else begin
         if (accept) begin
            ifq[ifq_wr] <= fetch_pc;
            ifq_wr      <= ifq_wr + PW'(1);
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (resp_take) begin
            buf_pc[buf_wr]   <= ifq[ifq_rd];
            buf_inst[buf_wr] <= imem_resp_data;
            buf_wr           <= buf_wr + PW'(1);
            ifq_rd           <= ifq_rd + PW'(1);
         end
         if (pop)
            buf_rd <= buf_rd + PW'(1);
         ifq_cnt  <= ifq_cnt + CW'(accept) - CW'(resp_take);
         buf_cnt  <= buf_cnt + CW'(resp_take) - CW'(pop);
         drop_cnt <= drop_cnt - CW'(resp_drop);
      end
   end

   // A response with nothing outstanding is a memory protocol error.
   always_ff @(posedge clk) begin
      if (!rst)
         assert (!(imem_resp_valid && ifq_cnt == '0
                   && drop_cnt == '0));
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors, redirect and
// reset sequences, and random traffic against a stream-level model.
module tb_fetch_unit;

   localparam int          DEPTH   = 2;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_PC;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_PC;
   logic        inst_ready;

   logic        w_redirect_valid;
   logic [31:0] w_redirect_PC;
   logic        w_req_valid;
   logic [31:0] w_req_addr;
   logic        w_req_ready;
   logic        w_resp_valid;
   logic [31:0] w_resp_data;
   logic        w_inst_valid;
   logic [31:0] w_inst;
   logic [31:0] w_inst_PC;
   logic        w_inst_ready;

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_PC    (redirect_PC),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_PC        (inst_PC),
      .inst_ready     (inst_ready)
   );

   fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (w_redirect_valid),
      .redirect_PC    (w_redirect_PC),
      .imem_req_valid (w_req_valid),
      .imem_req_addr  (w_req_addr),
      .imem_req_ready (w_req_ready),
      .imem_resp_valid(w_resp_valid),
      .imem_resp_data (w_resp_data),
      .inst_valid     (w_inst_valid),
      .inst           (w_inst),
      .inst_PC        (w_inst_PC),
      .inst_ready     (w_inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          ep;
   } mreq_t;

   typedef struct {
      bit          ir;
      bit          rv;
      logic [31:0] ra;
      bit          iv;
      logic [31:0] ipc;
   } vec_t;

   int          n_chk;
   int          n_fail;
   int          cyc;
   int          lat;
   int          epoch;
   int          pend;
   int          last_due;
   logic [31:0] exp_pc;
   logic [31:0] exp_req;
   logic [31:0] key;
   bit          iready;
   bit          rready;
   bit          s_rv;
   bit          s_iv;
   bit          s_resp;
   logic [31:0] s_ra;
   bit          w_pv;
   logic [31:0] w_pa;
   mreq_t       mem_q[$];
   logic [31:0] deliv[$];
   logic [31:0] w_deliv[$];
   vec_t        tbl[16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: memory model drives responses, DUT outputs are
   // checked against the delivered-stream model, then the model steps.
   task automatic cycle(input bit redir, input logic [31:0] rpc);
      mreq_t m;
      bit    stale;
      bit    mpop;
      int    occ;
      int    d;
      @(posedge clk);
      #1;
      cyc++;
      stale = 1'b0;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         m = mem_q.pop_front();
         imem_resp_valid = 1'b1;
         imem_resp_data  = m.addr ^ key;
         stale = (m.ep != epoch);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      imem_req_ready = rready;
      inst_ready     = iready;
      redirect_valid = redir;
      redirect_PC    = rpc;
      w_resp_valid   = w_pv;
      w_resp_data    = w_pa;
      w_req_ready    = 1'b1;
      w_inst_ready   = 1'b1;
      #1;
      s_rv   = imem_req_valid;
      s_ra   = imem_req_addr;
      s_iv   = inst_valid;
      s_resp = imem_resp_valid;
      occ  = mem_q.size() + int'(imem_resp_valid) + pend;
      mpop = (pend != 0) && iready;
      chk("inst_valid", 32'(inst_valid), 32'(pend != 0));
      chk("req_valid", 32'(imem_req_valid),
          32'(!redir && (occ - int'(mpop) < DEPTH)));
      if (imem_req_valid && rready) begin
         chk("req_addr", imem_req_addr, exp_req);
         d = cyc + lat;
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         mem_q.push_back('{imem_req_addr, d, epoch});
         exp_req = exp_req + 32'd4;
      end
      if (mpop && !redir) begin
         chk("deliver_pc", inst_PC, exp_pc);
         chk("deliver_inst", inst, exp_pc ^ key);
         deliv.push_back(inst_PC);
         exp_pc = exp_pc + 32'd4;
         pend--;
      end
      if (imem_resp_valid && !redir && !stale) pend++;
      if (redir) begin
         pend    = 0;
         epoch++;
         exp_pc  = {rpc[31:2], 2'b00};
         exp_req = exp_pc;
      end
      if (w_inst_valid) begin
         chk("wrap_data", w_inst, w_inst_PC);
         w_deliv.push_back(w_inst_PC);
      end
      w_pv = w_req_valid;
      w_pa = w_req_addr;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_PC     = '0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      inst_ready      = 1'b0;
      w_req_ready     = 1'b0;
      w_resp_valid    = 1'b0;
      w_resp_data     = '0;
      w_inst_ready    = 1'b0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_PC, 32'd0);
      mem_q.delete();
      deliv.delete();
      w_deliv.delete();
      pend     = 0;
      epoch    = 0;
      last_due = 0;
      exp_pc   = 32'h0;
      exp_req  = 32'h0;
      w_pv     = 1'b0;
      w_pa     = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("post_rst_req_addr", imem_req_addr, 32'h0);
      chk("post_rst_wrap_addr", w_req_addr, WRAP_PC);
   endtask

   initial begin
      bit          found;
      bit          redir;
      logic [31:0] rpc;

      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      key    = 32'h0;
      lat    = 1;
      iready = 1'b1;
      rready = 1'b1;
      w_redirect_valid = 1'b0;
      w_redirect_PC    = '0;

      // Sequential fetch then 6 cycles of decode backpressure.
      tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
      for (int i = 6; i < 12; i++)
         tbl[i] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
      tbl[12] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
      tbl[13] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
      tbl[14] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
      tbl[15] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};

      rst = 1'b1;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         iready = tbl[i].ir;
         cycle(1'b0, 32'h0);
         chk("vec_req_valid", 32'(s_rv), 32'(tbl[i].rv));
         if (tbl[i].rv) chk("vec_req_addr", s_ra, tbl[i].ra);
         chk("vec_inst_valid", 32'(s_iv), 32'(tbl[i].iv));
         if (tbl[i].iv) begin
            chk("vec_inst_pc", inst_PC, tbl[i].ipc);
            chk("vec_inst", inst, tbl[i].ipc);
         end
      end

      chk("wrap_count", 32'(w_deliv.size() >= 3), 32'd1);
      if (w_deliv.size() >= 3) begin
         chk("wrap_pc0", w_deliv[0], 32'hFFFF_FFF8);
         chk("wrap_pc1", w_deliv[1], 32'hFFFF_FFFC);
         chk("wrap_pc2", w_deliv[2], 32'h0000_0000);
      end

      // Redirect while 0x8 and 0xC are outstanding, 3-cycle memory.
      do_reset();
      lat    = 3;
      iready = 1'b1;
      rready = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b0, 32'h0);
         if (mem_q.size() == 2 && mem_q[0].addr == 32'h8
             && mem_q[1].addr == 32'hC)
            found = 1'b1;
      end
      chk("redir1_setup", 32'(found), 32'd1);
      deliv.delete();
      cycle(1'b1, 32'h100);
      repeat (14) cycle(1'b0, 32'h0);
      chk("redir1_count", 32'(deliv.size() >= 2), 32'd1);
      if (deliv.size() >= 2) begin
         chk("redir1_pc0", deliv[0], 32'h100);
         chk("redir1_pc1", deliv[1], 32'h104);
      end

      // Redirect with buffered entry and a response in the same cycle.
      do_reset();
      lat    = 1;
      iready = 1'b0;
      rready = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle(1'b0, 32'h0);
         if (pend != 0 && mem_q.size() != 0
             && mem_q[0].due == cyc + 1)
            found = 1'b1;
      end
      chk("redir2_setup", 32'(found), 32'd1);
      cycle(1'b1, 32'h203);
      chk("redir2_resp", 32'(s_resp), 32'd1);
      chk("redir2_buffered", 32'(s_iv), 32'd1);
      deliv.delete();
      cycle(1'b0, 32'h0);
      chk("redir2_flushed", 32'(s_iv), 32'd0);
      chk("redir2_req_valid", 32'(s_rv), 32'd1);
      chk("redir2_req_addr", s_ra, 32'h200);
      iready = 1'b1;
      repeat (6) cycle(1'b0, 32'h0);
      chk("redir2_count", 32'(deliv.size() >= 2), 32'd1);
      if (deliv.size() >= 2) begin
         chk("redir2_pc0", deliv[0], 32'h200);
         chk("redir2_pc1", deliv[1], 32'h204);
      end

      // Asynchronous reset with work buffered and in flight.
      do_reset();
      lat    = 2;
      iready = 1'b0;
      rready = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b0, 32'h0);
         if (pend != 0 && mem_q.size() != 0) found = 1'b1;
      end
      chk("areset_setup", 32'(found), 32'd1);
      @(posedge clk);
      #1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      inst_ready      = 1'b0;
      #2;
      chk("areset_pre_valid", 32'(inst_valid), 32'd1);
      do_reset();
      lat    = 1;
      iready = 1'b1;
      repeat (6) cycle(1'b0, 32'h0);
      chk("areset_count", 32'(deliv.size() >= 1), 32'd1);
      if (deliv.size() >= 1)
         chk("areset_first_pc", deliv[0], 32'h0);

      // Random traffic against the stream model.
      do_reset();
      key = 32'hC3A5_0F1E;
      for (int i = 0; i < 2000; i++) begin
         rready = ($urandom_range(0, 3) != 0);
         iready = ($urandom_range(0, 3) != 0);
         lat    = $urandom_range(1, 4);
         redir  = ($urandom_range(0, 24) == 0);
         rpc    = $urandom;
         if ($urandom_range(0, 3) == 0)
            rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
         cycle(redir, rpc);
      end
      chk("random_progress", 32'(deliv.size() > 50), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
